exception_sequencer: RTL and testbench
======================================

Name: exception_sequencer

Overview:
- Controls exception entry and exception return for the banked ARM register file.
- Latches and prioritises exception requests and waits for an instruction boundary while holding the core.
- Drives the register file's write port, PC port and mode input through a fixed multi-cycle sequence: save SPSR, switch mode, write banked LR, load vector.
- Sits between the core control unit and the register file and owns all mode-switch writes.

Parameters:
- VECTOR_BASE, 32'h0000_0000, base address added to the vector offset.
- DATA_W, 32, register and PC width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_und  in  1  undefined-instruction pulse; latched.
- req_svc  in  1  SVC pulse; latched.
- req_pabt  in  1  prefetch-abort pulse; latched.
- req_dabt  in  1  data-abort pulse; latched.
- irq  in  1  level interrupt; not latched.
- fiq  in  1  level fast interrupt; not latched.
- eret  in  1  exception-return request pulse; latched.
- boundary  in  1  core is at an instruction boundary.
- cur_pc  in  DATA_W  address of the instruction at the boundary.
- cpsr  in  DATA_W  current CPSR: M=[4:0], F=[6], I=[7].
- spsr_rd  in  DATA_W  SPSR of the current mode.
- lr_rd  in  DATA_W  banked r14 of the current mode.
- hold  out  1  stall the core.
- mode_ovr  out  5  mode driven to the register file M.
- mode_ovr_en  out  1  mode_ovr is valid.
- w_addr  out  4  register write address.
- w_data  out  DATA_W  register write data.
- write_reg  out  1  register write strobe.
- write_pc  out  1  PC write strobe.
- pc_data  out  DATA_W  new PC.
- spsr_we  out  1  write spsr_wd into the SPSR of mode_ovr.
- spsr_wd  out  DATA_W  SPSR write data.
- cpsr_we  out  1  CPSR write strobe.
- cpsr_wd  out  DATA_W  CPSR write data.
- exc_taken  out  1  one-cycle pulse at sequence end.
- exc_code  out  3  taken exception: 1 und, 2 svc, 3 pabt, 4 dabt, 6 irq, 7 fiq, 5 eret.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Pending bits for und, svc, pabt, dabt and eret cleared.
  - Reset mid-sequence aborts with no further strobes.
- Latching: req_* and eret pulses set their pending bit every cycle, including while busy. A bit is cleared only in the SEL cycle of the sequence that consumes it.
- Effective requests:
  - fiq_eff = fiq & ~cpsr[6].
  - irq_eff = irq & ~cpsr[7].
- Priority, highest first: dabt, fiq_eff, irq_eff, pabt, und, svc, eret.
- States:
  - IDLE: hold=0. If any effective request is set and boundary=1, go to SEL; hold=1 from the next cycle.
  - SEL: register the winner, target mode, vector offset, LR value and the old CPSR. Clear the winner's pending bit. eret goes to RET_CPSR; everything else goes to SAVE.
  - SAVE: spsr_we=1, spsr_wd=old CPSR, mode_ovr=target, mode_ovr_en=1.
  - SWMODE: cpsr_we=1.
    - cpsr_wd = old CPSR with M=target and I=1.
    - F=1 only for fiq, otherwise the old F is kept.
  - WRLR: write_reg=1, w_addr=14, w_data=cur_pc(latched)+LR_OFF, mode_ovr=target, mode_ovr_en=1.
  - WRPC: write_pc=1, pc_data=VECTOR_BASE+offset; exc_taken=1; go to IDLE.
  - RET_CPSR: cpsr_we=1, cpsr_wd=spsr_rd; pc_data is captured from lr_rd in the same cycle.
  - RET_PC: write_pc=1, pc_data=captured LR; exc_taken=1; go to IDLE.
- Per-exception table (target mode / vector offset / LR_OFF):
  - und: 11011 / 0x04 / +4.
  - svc: 10011 / 0x08 / +4.
  - pabt: 10111 / 0x0C / +4.
  - dabt: 10111 / 0x10 / +8.
  - irq: 10010 / 0x18 / +4.
  - fiq: 10001 / 0x1C / +4.
- Latency: entry takes 5 cycles, SEL through WRPC. Return takes 3 cycles.
- Outputs are registered; each strobe is high for exactly one cycle.
- Boundary conditions:
  - If irq/fiq deassert after SEL, the sequence still completes.
  - If eret is pending while in user mode (M=10000) or system mode (M=11111): the bit is dropped, exc_code=5, exc_taken pulses, and no writes occur.
  - Back-to-back requests: after WRPC the FSM returns to IDLE for at least 1 cycle before the next SEL.
  - The new mask applies to the next selection, so an irq arriving during a fiq entry is masked afterwards.
  - LR arithmetic wraps modulo 2^DATA_W.

Decomposition:
- Package exc_pkg holds:
  - mode encodings (MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC, MODE_ABT, MODE_UND, MODE_SYS);
  - the exc_code constants;
  - vector offsets and LR offsets;
  - the FSM state encoding.
- One combinational sub-module, exc_prio_enc: inputs are the pending bits, fiq/irq and the I/F masks; outputs are the winner code, target mode, vector offset and LR offset.

Test Plan:
- Reset: rst=1 mid-WRLR -> next cycle all strobes 0 and hold=0; no write_pc follows.
- SVC entry: cpsr M=10000, req_svc pulse, cur_pc=0x100, boundary=1. Expected: spsr_we with 0x10; cpsr_wd M=10011, I=1; w_addr=14, w_data=0x104; pc_data=0x08; exc_code=2.
- Priority: req_dabt and irq together with cur_pc=0x200. Expected: dabt first (LR=0x208, PC=0x10, mode 10111), then irq (PC=0x18) is blocked because I=1 after entry.
- Masking: fiq=1 with F=1 -> no entry. Clearing F -> entry with mode 10001, F=1, PC=0x1C.
- Return: in SVC with spsr_rd=0x10 and lr_rd=0x104, eret pulse -> cpsr_wd=0x10, then pc_data=0x104, 3 cycles total.
- No boundary: req_und held pending with boundary=0 for 10 cycles -> no strobes. boundary=1 -> entry to mode 11011, PC=0x04.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared encodings for the exception sequencer: processor modes, exception
// codes, vector/LR offsets, pending-bit layout and FSM states.
package exc_pkg;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    localparam logic [2:0] EXC_NONE = 3'd0;
    localparam logic [2:0] EXC_UND  = 3'd1;
    localparam logic [2:0] EXC_SVC  = 3'd2;
    localparam logic [2:0] EXC_PABT = 3'd3;
    localparam logic [2:0] EXC_DABT = 3'd4;
    localparam logic [2:0] EXC_ERET = 3'd5;
    localparam logic [2:0] EXC_IRQ  = 3'd6;
    localparam logic [2:0] EXC_FIQ  = 3'd7;

    localparam logic [7:0] VEC_UND  = 8'h04;
    localparam logic [7:0] VEC_SVC  = 8'h08;
    localparam logic [7:0] VEC_PABT = 8'h0C;
    localparam logic [7:0] VEC_DABT = 8'h10;
    localparam logic [7:0] VEC_IRQ  = 8'h18;
    localparam logic [7:0] VEC_FIQ  = 8'h1C;

    localparam logic [3:0] LR_OFF_STD  = 4'd4;
    localparam logic [3:0] LR_OFF_DABT = 4'd8;

    // Only the pulse-type requests own a pending bit; irq/fiq are levels.
    localparam int PEND_W = 5;
    localparam int P_UND  = 0;
    localparam int P_SVC  = 1;
    localparam int P_PABT = 2;
    localparam int P_DABT = 3;
    localparam int P_ERET = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEL      = 3'd1,
        S_SAVE     = 3'd2,
        S_SWMODE   = 3'd3,
        S_WRLR     = 3'd4,
        S_WRPC     = 3'd5,
        S_RET_CPSR = 3'd6,
        S_RET_PC   = 3'd7
    } state_e;

    function automatic logic [PEND_W-1:0] pend_mask(input logic [2:0] code);
        logic [PEND_W-1:0] m;
        case (code)
            EXC_UND:  m = 5'b00001;
            EXC_SVC:  m = 5'b00010;
            EXC_PABT: m = 5'b00100;
            EXC_DABT: m = 5'b01000;
            EXC_ERET: m = 5'b10000;
            default:  m = 5'b00000;
        endcase
        return m;
    endfunction

    function automatic logic is_unbanked_mode(input logic [4:0] m);
        return (m == MODE_USR) || (m == MODE_SYS);
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: picks the winning exception and looks up
// its target mode, vector offset and LR adjustment.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic [PEND_W-1:0] pend_i,
    input  logic              irq_i,
    input  logic              fiq_i,
    input  logic              i_mask_i,
    input  logic              f_mask_i,
    output logic              valid_o,
    output logic [2:0]        code_o,
    output logic [4:0]        mode_o,
    output logic [7:0]        vec_o,
    output logic [3:0]        lr_off_o
);

    logic fiq_eff_s;
    logic irq_eff_s;

    assign fiq_eff_s = fiq_i & ~f_mask_i;
    assign irq_eff_s = irq_i & ~i_mask_i;

    // Fixed priority: dabt > fiq > irq > pabt > und > svc > eret
    always_comb begin
        valid_o  = 1'b1;
        code_o   = EXC_NONE;
        mode_o   = MODE_USR;
        vec_o    = 8'h00;
        lr_off_o = 4'd0;
        if (pend_i[P_DABT]) begin
            code_o   = EXC_DABT;
            mode_o   = MODE_ABT;
            vec_o    = VEC_DABT;
            lr_off_o = LR_OFF_DABT;
        end else if (fiq_eff_s) begin
            code_o   = EXC_FIQ;
            mode_o   = MODE_FIQ;
            vec_o    = VEC_FIQ;
            lr_off_o = LR_OFF_STD;
        end else if (irq_eff_s) begin
            code_o   = EXC_IRQ;
            mode_o   = MODE_IRQ;
            vec_o    = VEC_IRQ;
            lr_off_o = LR_OFF_STD;
        end else if (pend_i[P_PABT]) begin
            code_o   = EXC_PABT;
            mode_o   = MODE_ABT;
            vec_o    = VEC_PABT;
            lr_off_o = LR_OFF_STD;
        end else if (pend_i[P_UND]) begin
            code_o   = EXC_UND;
            mode_o   = MODE_UND;
            vec_o    = VEC_UND;
            lr_off_o = LR_OFF_STD;
        end else if (pend_i[P_SVC]) begin
            code_o   = EXC_SVC;
            mode_o   = MODE_SVC;
            vec_o    = VEC_SVC;
            lr_off_o = LR_OFF_STD;
        end else if (pend_i[P_ERET]) begin
            code_o   = EXC_ERET;
        end else begin
            valid_o  = 1'b0;
        end
    end

endmodule

// File: rtl/exception_sequencer.sv
// Exception entry/return sequencer: owns every mode-switch write to the banked
// register file and walks SPSR save, mode switch, LR write and vector load.
module exception_sequencer
    import exc_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] VECTOR_BASE = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_und,
    input  logic              req_svc,
    input  logic              req_pabt,
    input  logic              req_dabt,
    input  logic              irq,
    input  logic              fiq,
    input  logic              eret,
    input  logic              boundary,
    input  logic [DATA_W-1:0] cur_pc,
    input  logic [DATA_W-1:0] cpsr,
    input  logic [DATA_W-1:0] spsr_rd,
    input  logic [DATA_W-1:0] lr_rd,
    output logic              hold,
    output logic [4:0]        mode_ovr,
    output logic              mode_ovr_en,
    output logic [3:0]        w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              write_reg,
    output logic              write_pc,
    output logic [DATA_W-1:0] pc_data,
    output logic              spsr_we,
    output logic [DATA_W-1:0] spsr_wd,
    output logic              cpsr_we,
    output logic [DATA_W-1:0] cpsr_wd,
    output logic              exc_taken,
    output logic [2:0]        exc_code
);

    state_e              state_q;
    logic [PEND_W-1:0]   pend_q;
    logic [PEND_W-1:0]   pend_d;
    logic [PEND_W-1:0]   clr_s;

    logic [2:0]          code_q;
    logic [4:0]          mode_q;
    logic [7:0]          vec_q;
    logic [3:0]          lr_off_q;
    logic [DATA_W-1:0]   pc_q;
    logic [DATA_W-1:0]   cpsr_old_q;
    logic [DATA_W-1:0]   lr_cap_q;

    logic                win_valid_s;
    logic [2:0]          win_code_s;
    logic [4:0]          win_mode_s;
    logic [7:0]          win_vec_s;
    logic [3:0]          win_lr_off_s;
    logic [DATA_W-1:0]   cpsr_sw_s;
    logic [DATA_W-1:0]   lr_val_s;
    logic [DATA_W-1:0]   vec_addr_s;

    exc_prio_enc u_prio (
        .pend_i   (pend_q),
        .irq_i    (irq),
        .fiq_i    (fiq),
        .i_mask_i (cpsr[7]),
        .f_mask_i (cpsr[6]),
        .valid_o  (win_valid_s),
        .code_o   (win_code_s),
        .mode_o   (win_mode_s),
        .vec_o    (win_vec_s),
        .lr_off_o (win_lr_off_s)
    );

    // Pending bits: a new pulse always sets, only SEL clears the consumed bit
    always_comb begin
        clr_s = {PEND_W{1'b0}};
        if (state_q == S_SEL) begin
            clr_s = pend_mask(win_code_s);
        end else begin
            clr_s = {PEND_W{1'b0}};
        end
        pend_d = (pend_q & ~clr_s) | {eret, req_dabt, req_pabt, req_svc, req_und};
    end

    // New CPSR for the mode switch: target mode, IRQ masked, FIQ masked on fiq only
    always_comb begin
        cpsr_sw_s      = cpsr_old_q;
        cpsr_sw_s[4:0] = mode_q;
        cpsr_sw_s[7]   = 1'b1;
        if (code_q == EXC_FIQ) begin
            cpsr_sw_s[6] = 1'b1;
        end else begin
            cpsr_sw_s[6] = cpsr_old_q[6];
        end
    end

    assign lr_val_s   = pc_q + {{(DATA_W-4){1'b0}}, lr_off_q};
    assign vec_addr_s = VECTOR_BASE + {{(DATA_W-8){1'b0}}, vec_q};

    // Pending request register
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= {PEND_W{1'b0}};
        end else begin
            pend_q <= pend_d;
        end
    end

    // Sequencer FSM; every output is registered and defaults low each cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold        <= 1'b0;
            mode_ovr    <= 5'd0;
            mode_ovr_en <= 1'b0;
            w_addr      <= 4'd0;
            w_data      <= {DATA_W{1'b0}};
            write_reg   <= 1'b0;
            write_pc    <= 1'b0;
            pc_data     <= {DATA_W{1'b0}};
            spsr_we     <= 1'b0;
            spsr_wd     <= {DATA_W{1'b0}};
            cpsr_we     <= 1'b0;
            cpsr_wd     <= {DATA_W{1'b0}};
            exc_taken   <= 1'b0;
            exc_code    <= 3'd0;
            code_q      <= EXC_NONE;
            mode_q      <= 5'd0;
            vec_q       <= 8'h00;
            lr_off_q    <= 4'd0;
            pc_q        <= {DATA_W{1'b0}};
            cpsr_old_q  <= {DATA_W{1'b0}};
            lr_cap_q    <= {DATA_W{1'b0}};
        end else begin
            mode_ovr    <= 5'd0;
            mode_ovr_en <= 1'b0;
            w_addr      <= 4'd0;
            w_data      <= {DATA_W{1'b0}};
            write_reg   <= 1'b0;
            write_pc    <= 1'b0;
            pc_data     <= {DATA_W{1'b0}};
            spsr_we     <= 1'b0;
            spsr_wd     <= {DATA_W{1'b0}};
            cpsr_we     <= 1'b0;
            cpsr_wd     <= {DATA_W{1'b0}};
            exc_taken   <= 1'b0;
            exc_code    <= 3'd0;
            case (state_q)
                S_IDLE: begin
                    if (win_valid_s && boundary) begin
                        state_q <= S_SEL;
                        hold    <= 1'b1;
                    end else begin
                        hold    <= 1'b0;
                    end
                end
                S_SEL: begin
                    // A level request may vanish between IDLE and SEL
                    if (!win_valid_s) begin
                        state_q <= S_IDLE;
                        hold    <= 1'b0;
                    end else if (win_code_s == EXC_ERET) begin
                        if (is_unbanked_mode(cpsr[4:0])) begin
                            state_q   <= S_IDLE;
                            hold      <= 1'b0;
                            exc_taken <= 1'b1;
                            exc_code  <= EXC_ERET;
                        end else begin
                            state_q  <= S_RET_CPSR;
                            cpsr_we  <= 1'b1;
                            cpsr_wd  <= spsr_rd;
                            lr_cap_q <= lr_rd;
                        end
                    end else begin
                        state_q     <= S_SAVE;
                        code_q      <= win_code_s;
                        mode_q      <= win_mode_s;
                        vec_q       <= win_vec_s;
                        lr_off_q    <= win_lr_off_s;
                        pc_q        <= cur_pc;
                        cpsr_old_q  <= cpsr;
                        spsr_we     <= 1'b1;
                        spsr_wd     <= cpsr;
                        mode_ovr    <= win_mode_s;
                        mode_ovr_en <= 1'b1;
                    end
                end
                S_SAVE: begin
                    state_q <= S_SWMODE;
                    cpsr_we <= 1'b1;
                    cpsr_wd <= cpsr_sw_s;
                end
                S_SWMODE: begin
                    state_q     <= S_WRLR;
                    write_reg   <= 1'b1;
                    w_addr      <= 4'd14;
                    w_data      <= lr_val_s;
                    mode_ovr    <= mode_q;
                    mode_ovr_en <= 1'b1;
                end
                S_WRLR: begin
                    state_q   <= S_WRPC;
                    write_pc  <= 1'b1;
                    pc_data   <= vec_addr_s;
                    exc_taken <= 1'b1;
                    exc_code  <= code_q;
                end
                S_WRPC: begin
                    state_q <= S_IDLE;
                    hold    <= 1'b0;
                end
                S_RET_CPSR: begin
                    state_q   <= S_RET_PC;
                    write_pc  <= 1'b1;
                    pc_data   <= lr_cap_q;
                    exc_taken <= 1'b1;
                    exc_code  <= EXC_ERET;
                end
                S_RET_PC: begin
                    state_q <= S_IDLE;
                    hold    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    hold    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_sequencer.sv
// Self-checking bench: table of entry scenarios plus hand sequences for
// return, dropped eret, back-to-back and mid-sequence reset.
module tb_exception_sequencer;
    import exc_pkg::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, req_und, req_svc, req_pabt, req_dabt, irq, fiq, eret, boundary;
    logic [DW-1:0] cur_pc, cpsr, spsr_rd, lr_rd;
    logic          hold, mode_ovr_en, write_reg, write_pc, spsr_we, cpsr_we, exc_taken;
    logic [4:0]    mode_ovr;
    logic [3:0]    w_addr;
    logic [DW-1:0] w_data, pc_data, spsr_wd, cpsr_wd;
    logic [2:0]    exc_code;

    always #5 clk = ~clk;

    exception_sequencer #(.DATA_W(DW), .VECTOR_BASE(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .req_und(req_und), .req_svc(req_svc), .req_pabt(req_pabt),
        .req_dabt(req_dabt), .irq(irq), .fiq(fiq), .eret(eret), .boundary(boundary),
        .cur_pc(cur_pc), .cpsr(cpsr), .spsr_rd(spsr_rd), .lr_rd(lr_rd), .hold(hold),
        .mode_ovr(mode_ovr), .mode_ovr_en(mode_ovr_en), .w_addr(w_addr), .w_data(w_data),
        .write_reg(write_reg), .write_pc(write_pc), .pc_data(pc_data), .spsr_we(spsr_we),
        .spsr_wd(spsr_wd), .cpsr_we(cpsr_we), .cpsr_wd(cpsr_wd), .exc_taken(exc_taken),
        .exc_code(exc_code)
    );

    // strobe bits: {taken, write_pc, write_reg, cpsr_we, spsr_we}
    localparam logic [4:0] ST_SPSR  = 5'b00001;
    localparam logic [4:0] ST_CPSR  = 5'b00010;
    localparam logic [4:0] ST_WREG  = 5'b00100;
    localparam logic [4:0] ST_WPC   = 5'b01000;
    localparam logic [4:0] ST_TAKEN = 5'b10000;

    typedef struct packed {
        logic [4:0]  strb;
        logic [31:0] data;
        logic [4:0]  mode;
        logic [3:0]  addr;
        logic [2:0]  code;
    } ev_t;

    ev_t exp_q[$];
    int  chk_cnt  = 0;
    int  pass_cnt = 0;

    function automatic ev_t mk(logic [4:0] s, logic [31:0] d, logic [4:0] m, logic [3:0] a, logic [2:0] c);
        ev_t e;
        e.strb = s; e.data = d; e.mode = m; e.addr = a; e.code = c;
        return e;
    endfunction

    // Scoreboard: every strobe cycle must match the next queued expectation
    always @(negedge clk) begin
        ev_t o, e;
        if (!rst && (spsr_we || cpsr_we || write_reg || write_pc || exc_taken)) begin
            o.strb = {exc_taken, write_pc, write_reg, cpsr_we, spsr_we};
            o.data = spsr_we ? spsr_wd : cpsr_we ? cpsr_wd : write_reg ? w_data : write_pc ? pc_data : 32'h0;
            o.mode = mode_ovr_en ? mode_ovr : 5'd0;
            o.addr = write_reg ? w_addr : 4'd0;
            o.code = exc_taken ? exc_code : 3'd0;
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL strobe_unexpected: got strb=%b data=%h mode=%b code=%0d, required no strobe",
                         o.strb, o.data, o.mode, o.code);
            end else begin
                e = exp_q.pop_front();
                if (o == e) pass_cnt++;
                else $display("FAIL strobe_event: got strb=%b data=%h mode=%b addr=%0d code=%0d, required strb=%b data=%h mode=%b addr=%0d code=%0d",
                              o.strb, o.data, o.mode, o.addr, o.code, e.strb, e.data, e.mode, e.addr, e.code);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Clock step; the bench plays register file and applies CPSR writes
    task automatic tick();
        @(posedge clk);
        #1;
        if (cpsr_we) cpsr = cpsr_wd;
    endtask

    task automatic push_entry(logic [31:0] old_cpsr, logic [4:0] mode, logic [31:0] new_cpsr,
                              logic [31:0] lr, logic [31:0] pc, logic [2:0] code);
        exp_q.push_back(mk(ST_SPSR, old_cpsr, mode, 4'd0, 3'd0));
        exp_q.push_back(mk(ST_CPSR, new_cpsr, 5'd0, 4'd0, 3'd0));
        exp_q.push_back(mk(ST_WREG, lr, mode, 4'd14, 3'd0));
        exp_q.push_back(mk(ST_WPC | ST_TAKEN, pc, 5'd0, 4'd0, code));
    endtask

    task automatic wait_taken(input string name, input int budget, input bit drop, inout int hold_n);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (hold) hold_n++;
            if (drop && hold_n >= 2) begin irq = 1'b0; fiq = 1'b0; end
            if (exc_taken) seen = 1'b1;
        end
        chk({name, "_taken_seen"}, {63'd0, seen}, 64'd1);
    endtask

    typedef struct {
        logic [3:0]  req;      // {dabt, pabt, svc, und}
        logic        irq, fiq, drop;
        logic [31:0] pre_cpsr;
        logic        pre_bnd;
        int          pre_n;
        logic [31:0] cpsr, pc;
        logic [4:0]  mode;
        logic [31:0] cpsr_wd, lr, vec;
        logic [2:0]  code;
    } row_t;

    row_t rows[10];

    task automatic run_row(input int idx);
        row_t r = rows[idx];
        int   hold_n = 0;
        string nm = $sformatf("row%0d", idx);
        cur_pc   = r.pc;
        irq      = r.irq;
        fiq      = r.fiq;
        cpsr     = (r.pre_n > 0) ? r.pre_cpsr : r.cpsr;
        boundary = (r.pre_n > 0) ? r.pre_bnd : 1'b1;
        push_entry(r.cpsr, r.mode, r.cpsr_wd, r.lr, r.vec, r.code);
        {req_dabt, req_pabt, req_svc, req_und} = r.req;
        tick();
        {req_dabt, req_pabt, req_svc, req_und} = 4'b0000;
        if (hold) hold_n++;
        for (int i = 0; i < r.pre_n; i++) begin
            chk({nm, "_pre_hold"}, {63'd0, hold}, 64'd0);
            tick();
        end
        cpsr     = r.cpsr;
        boundary = 1'b1;
        wait_taken(nm, 30, r.drop, hold_n);
        chk({nm, "_hold_cycles"}, 64'(hold_n), 64'd5);
        tick();
        chk({nm, "_idle_gap"}, {63'd0, hold}, 64'd0);
        for (int i = 0; i < 4; i++) tick();
        irq = 1'b0;
        fiq = 1'b0;
        chk({nm, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold_n;
        int wpc_n;
        bit seen;
        //          req      irq   fiq   drop  pre_cpsr     bnd   n   cpsr          pc            mode      cpsr_wd       lr            vec    code
        rows[0] = '{4'b0010, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 0,  32'h10,       32'h100,      5'b10011, 32'h93,       32'h104,      32'h08, 3'd2};
        rows[1] = '{4'b0001, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 0,  32'h2000_0010, 32'h300,     5'b11011, 32'h2000_009B, 32'h304,     32'h04, 3'd1};
        rows[2] = '{4'b0100, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 0,  32'h10,       32'h400,      5'b10111, 32'h97,       32'h404,      32'h0C, 3'd3};
        rows[3] = '{4'b1000, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 0,  32'h10,       32'hFFFF_FFFC, 5'b10111, 32'h97,      32'h4,        32'h10, 3'd4};
        rows[4] = '{4'b1000, 1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 0,  32'h10,       32'h200,      5'b10111, 32'h97,       32'h208,      32'h10, 3'd4};
        rows[5] = '{4'b0000, 1'b1, 1'b0, 1'b1, 32'h0,       1'b1, 0,  32'h10,       32'h500,      5'b10010, 32'h92,       32'h504,      32'h18, 3'd6};
        rows[6] = '{4'b0000, 1'b0, 1'b1, 1'b0, 32'h50,      1'b1, 8,  32'h10,       32'h600,      5'b10001, 32'hD1,       32'h604,      32'h1C, 3'd7};
        rows[7] = '{4'b0001, 1'b0, 1'b0, 1'b0, 32'h10,      1'b0, 10, 32'h10,       32'h700,      5'b11011, 32'h9B,       32'h704,      32'h04, 3'd1};
        rows[8] = '{4'b0000, 1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 0,  32'h13,       32'h800,      5'b10010, 32'h92,       32'h804,      32'h18, 3'd6};
        rows[9] = '{4'b0000, 1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 0,  32'h10,       32'h900,      5'b10001, 32'hD1,       32'h904,      32'h1C, 3'd7};

        rst = 1'b1; req_und = 1'b0; req_svc = 1'b0; req_pabt = 1'b0; req_dabt = 1'b0;
        irq = 1'b0; fiq = 1'b0; eret = 1'b0; boundary = 1'b1;
        cur_pc = 32'h0; cpsr = 32'h10; spsr_rd = 32'h0; lr_rd = 32'h0;
        for (int i = 0; i < 3; i++) tick();
        chk("reset_outputs", {63'd0, |{hold, mode_ovr, mode_ovr_en, w_addr, w_data, write_reg, write_pc,
            pc_data, spsr_we, spsr_wd, cpsr_we, cpsr_wd, exc_taken, exc_code}}, 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_hold", {63'd0, hold}, 64'd0);

        for (int i = 0; i < 10; i++) run_row(i);

        // Exception return from SVC: 3 cycles, CPSR from SPSR then PC from LR
        cpsr = 32'h13; spsr_rd = 32'h10; lr_rd = 32'h104;
        exp_q.push_back(mk(ST_CPSR, 32'h10, 5'd0, 4'd0, 3'd0));
        exp_q.push_back(mk(ST_WPC | ST_TAKEN, 32'h104, 5'd0, 4'd0, 3'd5));
        hold_n = 0;
        eret = 1'b1; tick(); eret = 1'b0;
        if (hold) hold_n++;
        wait_taken("eret_svc", 20, 1'b0, hold_n);
        chk("eret_svc_hold_cycles", 64'(hold_n), 64'd3);
        for (int i = 0; i < 4; i++) tick();

        // eret in USR and SYS: dropped, code 5 taken, no writes
        for (int k = 0; k < 2; k++) begin
            cpsr = (k == 0) ? 32'h10 : 32'h1F;
            exp_q.push_back(mk(ST_TAKEN, 32'h0, 5'd0, 4'd0, 3'd5));
            hold_n = 0;
            eret = 1'b1; tick(); eret = 1'b0;
            wait_taken("eret_unbanked", 20, 1'b0, hold_n);
            for (int i = 0; i < 5; i++) tick();
            chk("eret_unbanked_queue", 64'(exp_q.size()), 64'd0);
        end

        // Back-to-back: und and svc together; und first, IDLE gap, then svc
        cpsr = 32'h10; cur_pc = 32'hA00;
        push_entry(32'h10, 5'b11011, 32'h9B, 32'hA04, 32'h04, 3'd1);
        push_entry(32'h9B, 5'b10011, 32'h93, 32'hA04, 32'h08, 3'd2);
        hold_n = 0;
        req_und = 1'b1; req_svc = 1'b1; tick(); req_und = 1'b0; req_svc = 1'b0;
        wait_taken("b2b_first", 20, 1'b0, hold_n);
        tick();
        chk("b2b_idle_gap", {63'd0, hold}, 64'd0);
        wait_taken("b2b_second", 20, 1'b0, hold_n);
        for (int i = 0; i < 4; i++) tick();
        chk("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset while in WRLR: no write_pc may follow
        cpsr = 32'h10; cur_pc = 32'hB00;
        exp_q.push_back(mk(ST_SPSR, 32'h10, 5'b10011, 4'd0, 3'd0));
        exp_q.push_back(mk(ST_CPSR, 32'h93, 5'd0, 4'd0, 3'd0));
        exp_q.push_back(mk(ST_WREG, 32'hB04, 5'b10011, 4'd14, 3'd0));
        req_svc = 1'b1; tick(); req_svc = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (write_reg) seen = 1'b1;
        end
        chk("rst_mid_wrlr_seen", {63'd0, seen}, 64'd1);
        @(negedge clk); #1;
        rst = 1'b1;
        tick();
        chk("rst_mid_strobes", {63'd0, |{hold, write_pc, write_reg, spsr_we, cpsr_we, exc_taken, mode_ovr_en}}, 64'd0);
        rst = 1'b0;
        wpc_n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (write_pc || hold) wpc_n++;
        end
        chk("rst_mid_no_followup", 64'(wpc_n), 64'd0);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
